instr_fetch_unit: RTL

Instruction fetch/issue block that feeds the control unit's `instr` input and closes the loop on its decoded branch/jump/halt outputs. It owns the program counter and requests instruction words from the instruction memory port. It presents one instruction at a time to the control unit, then computes the next PC from the control unit's `brnch_eq`/`brnch_ne`/`jmp`/`JR`/`cuHALT` decisions. It sits between the memory controller's instruction port and the control unit inside the single-cycle-style datapath.

---
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue: owns the PC, fetches one word, holds it for the control unit, then resolves next PC.
// Minimum 2 cycles per instruction; ihit delay and dstall each add a cycle; cuHALT is terminal until reset.
module instr_fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] iload,
   input  logic        dstall,
   input  logic        cuHALT,
   input  logic        brnch_eq,
   input  logic        brnch_ne,
   input  logic        jmp,
   input  logic        JR,
   input  logic        zero,
   input  logic [31:0] rdat1,
   output logic        iREN,
   output logic [31:0] iaddr,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc_plus4,
   output logic        halt
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      EXEC   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        instr_valid_q, instr_valid_d;
   logic        halt_q, halt_d;

   logic [31:0] jr_tgt, jmp_tgt, br_off, next_pc;
   logic        br_taken;

   assign pc_plus4 = pc_q + 32'd4;
   // Mask rather than slice so the whole register operand feeds the target.
   assign jr_tgt   = rdat1 & ~32'd3;
   assign jmp_tgt  = {pc_plus4[31:28], instr_q[25:0], 2'b00};
   assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   assign br_taken = (brnch_eq & zero) | (brnch_ne & ~zero);

   always_comb begin
      next_pc = pc_plus4;
      if (JR)
         next_pc = jr_tgt;
      else if (jmp)
         next_pc = jmp_tgt;
      else if (br_taken)
         next_pc = pc_plus4 + br_off;
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      halt_d        = halt_q;
      case (state_q)
         FETCH: begin
            if (ihit) begin
               instr_d       = iload;
               instr_valid_d = 1'b1;
               state_d       = EXEC;
            end
         end
         EXEC: begin
            // Halt wins over a pending data stall; PC stays on the halting instruction.
            if (cuHALT) begin
               halt_d        = 1'b1;
               instr_valid_d = 1'b0;
               state_d       = HALTED;
            end else if (!dstall) begin
               pc_d          = next_pc;
               instr_valid_d = 1'b0;
               state_d       = FETCH;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q       <= FETCH;
         pc_q          <= {PC_INIT[31:2], 2'b00};
         instr_q       <= 32'h0;
         instr_valid_q <= 1'b0;
         halt_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         halt_q        <= halt_d;
      end
   end

   assign iREN        = (state_q == FETCH);
   assign iaddr       = pc_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign halt        = halt_q;

endmodule
